stim_gen: RTL and testbench

Stimulus generator for `stim`, the spike-train source that drives neuron blocks such as `delay` in simulation and on the MKR Vidor 4000 FPGA. After reset it waits a programmable number of cycles, then emits a periodic, optionally bounded, train of fixed-width high pulses on a single registered output. An optional LFSR gate turns the train into pseudo-random spikes.

---
 rtl/stim_if.sv | 6 +
 rtl/stim_gen.sv | 85 ++++++++
 tb/tb_stim_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/stim_if.sv
// stim_if: spike-train output bundle between stim_gen and its consumers
interface stim_if;
  logic stim_out;
  modport master(output stim_out);
  modport slave(input stim_out);
endinterface

// File: rtl/stim_gen.sv
// stim_gen: delayed, periodic, optionally bounded spike train on a registered output.
// Define STIM_LFSR_EN to gate each slot with a 16-bit Galois LFSR against THRESHOLD.
module stim_gen #(
  parameter int START_DELAY = 2,
  parameter int PERIOD = 5,
  parameter int WIDTH = 1,
  parameter int BURST_COUNT = 0,
  parameter int LFSR_SEED = 16'hACE1,
  parameter int THRESHOLD = 8'd128
) (
  input logic clk,
  input logic rst,
  stim_if.master s
);
  localparam logic [1:0] WAIT = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3;
  localparam logic [15:0] SD = 16'(START_DELAY), P_LAST = 16'(PERIOD - 1), W = 16'(WIDTH), BC = 16'(BURST_COUNT);
  if (START_DELAY < 0 || START_DELAY > 65535) begin : g_chk_delay
    $error("stim_gen: START_DELAY out of range");
  end
  if (PERIOD < 2 || PERIOD > 65536) begin : g_chk_period
    $error("stim_gen: PERIOD must be at least 2");
  end
  if (WIDTH < 1 || WIDTH >= PERIOD) begin : g_chk_width
    $error("stim_gen: WIDTH must satisfy 1 <= WIDTH < PERIOD");
  end
  if (BURST_COUNT < 0 || BURST_COUNT > 65535) begin : g_chk_burst
    $error("stim_gen: BURST_COUNT out of range");
  end
  if (THRESHOLD < 0 || THRESHOLD > 255) begin : g_chk_thr
    $error("stim_gen: THRESHOLD out of range");
  end
  if (LFSR_SEED < 0 || LFSR_SEED > 65535) begin : g_chk_seed
    $error("stim_gen: LFSR_SEED out of range");
  end
  logic [1:0] state = WAIT;
  logic [15:0] dly = '0;
  logic [15:0] phase = '0;
  logic [15:0] slot = '0;
  logic en = 1'b0;
  logic out = 1'b0;
  logic slot_en, start, last;
  logic [1:0] nstate;
  logic [15:0] nphase;
  logic nen;
`ifdef STIM_LFSR_EN
  localparam logic [7:0] TH = 8'(THRESHOLD);
  if (LFSR_SEED == 0) begin : g_chk_seed_nz
    $error("stim_gen: LFSR_SEED must be nonzero");
  end
  logic [15:0] lfsr = 16'(LFSR_SEED);
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= 16'(LFSR_SEED);
    else lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign slot_en = lfsr[7:0] < TH;
`else
  assign slot_en = 1'b1;
`endif
  // A slot starts either when the start delay has elapsed or when the phase wraps
  assign start = (state == WAIT && dly == SD) || ((state == HIGH || state == LOW) && phase == P_LAST);
  assign last = BURST_COUNT != 0 && slot == BC;
  always_comb begin
    nphase = start ? '0 : phase + 16'd1;
    nen = start ? slot_en : en;
    nstate = (state == DONE || (start && last)) ? DONE :
             (state == WAIT && !start) ? WAIT :
             (nen && nphase < W) ? HIGH : LOW;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= WAIT;
      dly <= '0;
      phase <= '0;
      slot <= '0;
      en <= 1'b0;
      out <= 1'b0;
    end else begin
      state <= nstate;
      out <= nstate == HIGH;
      en <= nen;
      if (state == WAIT && !start) dly <= dly + 16'd1;
      if (nstate == HIGH || nstate == LOW) phase <= nphase;
      if (start && !last && BURST_COUNT != 0) slot <= slot + 16'd1;
    end
  assign s.stim_out = out;
endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: four stim_gen configurations checked every cycle against a closed-form
// spike-train model, with random asynchronous reset pulses and literal train checks.
module tb_stim_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  stim_if i0 ();
  stim_if i1 ();
  stim_if i2 ();
  stim_if i3 ();
  stim_gen u0 (.clk(clk), .rst(rst), .s(i0));
  stim_gen #(.START_DELAY(0), .PERIOD(4), .WIDTH(2), .BURST_COUNT(3)) u1 (.clk(clk), .rst(rst), .s(i1));
  stim_gen #(.START_DELAY(7), .PERIOD(6), .WIDTH(3), .BURST_COUNT(5), .THRESHOLD(255)) u2 (.clk(clk), .rst(rst), .s(i2));
  stim_gen #(.THRESHOLD(0)) u3 (.clk(clk), .rst(rst), .s(i3));
  wire [3:0] so = {i3.stim_out, i2.stim_out, i1.stim_out, i0.stim_out};
  int sd[4] = '{2, 0, 7, 2};
  int pr[4] = '{5, 4, 6, 5};
  int wd[4] = '{1, 2, 3, 1};
  int bc[4] = '{0, 3, 5, 0};
  int th[4] = '{128, 128, 255, 0};
  logic [15:0] hist [0:4095];
  logic [15:0] lf = 16'hACE1;
  int n = 0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Output after edge k of a run: in an active slot phase, slot within the burst, slot enabled
  function automatic logic model(input int d, input int p, input int w, input int b, input int t, input int k);
    int sl;
    if (k <= d) return 1'b0;
    sl = (k - d - 1) / p;
    if (b != 0 && sl >= b) return 1'b0;
    if ((k - d - 1) % p >= w) return 1'b0;
`ifdef STIM_LFSR_EN
    return int'(hist[d + 1 + sl * p][7:0]) < t;
`else
    return t >= 0;
`endif
  endfunction
  always @(posedge clk) begin
    if (!rst) begin
      n = 0;
      lf = 16'hACE1;
    end else begin
      n++;
      hist[n] = lf;
      lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    end
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("cycle_d%0d_n%0d", i, n), 64'(so[i]), 64'(model(sd[i], pr[i], wd[i], bc[i], th[i], n)));
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
  initial begin
    logic [63:0] got0, got1, got3, want0, want1;
    logic [2:0] rs;
    int hi0[10];
    int hi1[6];
    hi0 = '{3, 8, 13, 18, 23, 28, 33, 38, 43, 48};
    hi1 = '{1, 2, 5, 6, 9, 10};
    got0 = '0; got1 = '0; got3 = '0; want0 = '0; want1 = '0;
    foreach (hi0[i]) want0[hi0[i]] = 1'b1;
    foreach (hi1[i]) want1[hi1[i]] = 1'b1;
    #1;
    chk("powerup_low", 64'(so), 64'd0);
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #3;
      got0[k] = so[0];
      got1[k] = so[1];
      got3[k] = so[3];
    end
`ifndef STIM_LFSR_EN
    chk("lit_default_train", got0, want0);
    chk("lit_burst_train", 64'(got1[40:0]), 64'(want1[40:0]));
    chk("lit_th0_periodic", got3, want0);
`else
    chk("lit_th0_silent", got3, 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_high", 64'(so[0]), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_mid_pulse", 64'(so), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #3 rs[k] = so[0];
    end
    chk("restart_edge3", 64'(rs), 64'b100);
    repeat (20) begin
      repeat ($urandom_range(5, 120)) @(posedge clk);
      #($urandom_range(2, 8));
      rst = 1'b0;
      #1;
      chk("async_reset_random", 64'(so), 64'd0);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #($urandom_range(2, 8));
      rst = 1'b1;
    end
    repeat (1500) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
